match_signature_accum: RTL and testbench
========================================

Name: match_signature_accum

Overview:
- Downstream consumer of a registered match/compare stage, such as a wildcard set-membership flag.
- Folds each accepted result beat into a WIDTH-bit multiple-input signature register (MISR).
- Sequences three windows: warm-up (signature forced to zero), accumulate, then done with a compare against an expected constant.
- Replaces ad-hoc checksum logic in self-checking regression benches with one reusable, synthesizable block.

Parameters:
- WIDTH, 64, signature width; must be at least 3.
- IN_W, 1, result beat width; must satisfy 1 <= IN_W <= WIDTH.
- WARMUP_BEATS, 10, accepted beats during which the signature is held at zero.
- ACCUM_BEATS, 89, accepted beats folded into the signature after warm-up.
- EXPECTED, 64'h0, golden signature; truncated or zero-extended to WIDTH.

Ports:
- clk  input  1  sole clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a run; honoured only in IDLE or DONE.
- in_valid  input  1  a result beat is present this cycle.
- in_data  input  IN_W  result beat from the upstream match stage.
- busy  output  1  high in WARM or ACCUM.
- done  output  1  high in DONE.
- pass  output  1  signature == EXPECTED; valid only while done is high.
- signature  output  WIDTH  current signature register.
- beat_count  output  32  accepted beats since the last start.

Behaviour:
- Reset (async assert, sync release): state=IDLE; signature=0; beat_count=0; busy=0; done=0; pass=0.
- Feedback bit: fb = sig[WIDTH-1] ^ sig[2] ^ sig[0].
- Update: sig_next = zext(in_data, WIDTH) ^ {sig[WIDTH-2:0], fb}.
- A beat is accepted when in_valid=1 and state is WARM or ACCUM. No backpressure exists; beats outside those states are dropped.
- Each accepted beat increments beat_count by 1. beat_count saturates at 32'hFFFF_FFFF.
- IDLE: on start go to WARM; clear signature and beat_count on the same edge.
- WARM: each accepted beat writes signature=0. Transition to ACCUM on the edge of the WARMUP_BEATS-th accepted beat. If WARMUP_BEATS=0, start goes directly to ACCUM.
- ACCUM: each accepted beat applies sig_next. On the edge of the ACCUM_BEATS-th accepted beat (counted from entering ACCUM), go to DONE.
- DONE:
  - pass registers (sig_next == EXPECTED) on the entry edge, so done and pass rise together with no extra latency.
  - signature, pass and beat_count hold.
  - start re-enters WARM and clears state exactly as from IDLE.
- start while busy is ignored; no restart mid-run.
- in_valid=0 cycles stall the counters; the windows count beats, not clocks.
- rst_n asserted mid-run aborts immediately to reset values; no partial result is kept.
- start and in_valid together in IDLE/DONE: the beat is dropped; the first beat accepted is on the next cycle.

Optional Feature:
- Macro: MATCH_SIGNATURE_ONES_EN.
- When defined:
  - Extra output ones_count [31:0] counts in_data[0]==1 among beats accepted in ACCUM.
  - Cleared on start and on reset; held in DONE; saturating.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package match_sig_pkg holds:
  - typedef enum logic [1:0] {IDLE, WARM, ACCUM, DONE} msa_state_e;
  - localparam COUNT_W = 32;
  - function misr_step(sig, din), which computes sig_next.
- Sub-module misr_reg is natural: it holds the WIDTH-bit register with clear, hold and step controls.
- The FSM and counters stay in match_signature_accum.

Test Plan:
1. Defaults, rst_n low 3 cycles then high -> signature=0, beat_count=0, busy=0, done=0, pass=0.
2. WIDTH=8, WARMUP_BEATS=2, ACCUM_BEATS=3, in_data=1 every cycle, EXPECTED=8'h05, pulse start -> signature 0,0 then 8'h01, 8'h02, 8'h05; done and pass rise on the 5th accepted beat; beat_count=5.
3. Same as 2 with in_valid toggling 1,0,1,0,... -> identical final signature 8'h05; done occurs about 10 cycles after start instead of 5.
4. Same as 2 with in_data=0 and EXPECTED=8'h05 -> signature stays 8'h00; done=1, pass=0.
5. Pulse start again during ACCUM -> ignored, run completes unchanged. Then pulse rst_n low mid-run on a second run -> immediate IDLE and all outputs 0.
6. MATCH_SIGNATURE_ONES_EN defined, scenario 2 -> ones_count=3 at done; start from DONE -> ones_count=0 and a fresh run completes with 8'h05.

Source files
------------

// File: rtl/match_sig_pkg.sv
// rtl/match_sig_pkg.sv - shared types, constants and MISR step function for match_signature_accum
//
// Purpose : run-state encoding, counter width and the MISR next-state function.
// Contents: msa_state_e, COUNT_W, MISR_MAX_W, misr_step().
package match_sig_pkg;

  typedef enum logic [1:0] {IDLE, WARM, ACCUM, DONE} msa_state_e;

  localparam int COUNT_W = 32;

  // The step function works on a fixed wide vector so it can serve any WIDTH
  // up to this bound; callers zero-extend into it and truncate the result.
  localparam int MISR_MAX_W = 256;

  // sig_next = din ^ {sig[w-2:0], fb}, fb = sig[w-1] ^ sig[2] ^ sig[0],
  // with w = msb + 1. Bits at and above w are forced to zero.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] din,
    input logic [7:0]            msb
  );
    logic                  fb;
    logic [MISR_MAX_W-1:0] mask;
    fb   = sig[msb] ^ sig[2] ^ sig[0];
    mask = {MISR_MAX_W{1'b1}} >> (8'd255 - msb);
    return (din ^ {sig[MISR_MAX_W-2:0], fb}) & mask;
  endfunction

endpackage

// File: rtl/match_signature_accum_misr_reg.sv
// rtl/match_signature_accum_misr_reg.sv - WIDTH-bit MISR register with clear, step and hold
//
// Purpose : holds the signature; clear has priority over step, otherwise hold.
// Ports   : clk, rst_n        clock, async active-low reset
//           i_clear           force signature to zero on this edge
//           i_step            fold i_din into the signature on this edge
//           i_din  [IN_W]     beat to fold in (zero-extended)
//           o_sig  [WIDTH]    current signature
//           o_sig_next[WIDTH] value a step would produce this cycle
module misr_reg
  import match_sig_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int IN_W  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic [IN_W-1:0]  i_din,
  output logic [WIDTH-1:0] o_sig,
  output logic [WIDTH-1:0] o_sig_next
);

  logic [WIDTH-1:0] r_sig;

  assign o_sig_next = WIDTH'(misr_step(MISR_MAX_W'(r_sig), MISR_MAX_W'(i_din), 8'(WIDTH - 1)));
  assign o_sig      = r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (i_clear) begin
      r_sig <= '0;
    end else if (i_step) begin
      r_sig <= o_sig_next;
    end
  end

endmodule

// File: rtl/match_signature_accum.sv
// rtl/match_signature_accum.sv - warm-up / accumulate / done MISR signature sequencer
//
// Purpose : folds accepted result beats into a MISR over a warm-up window
//           (signature held at zero) and an accumulate window, then compares
//           against EXPECTED on entry to DONE.
// Ports   : clk, rst_n            clock, async active-low reset
//           start                begin a run (honoured in IDLE/DONE only)
//           in_valid, in_data    result beat; accepted only in WARM/ACCUM
//           busy, done, pass     status; pass meaningful while done
//           signature [WIDTH]    current signature
//           beat_count [32]      accepted beats since last start (saturating)
//           ones_count [32]      only with MATCH_SIGNATURE_ONES_EN: beats in
//                                ACCUM with in_data[0]==1 (saturating)
// Macro   : MATCH_SIGNATURE_ONES_EN enables ones_count.
module match_signature_accum
  import match_sig_pkg::*;
#(
  parameter int          WIDTH        = 64,
  parameter int          IN_W         = 1,
  parameter int unsigned WARMUP_BEATS = 10,
  parameter int unsigned ACCUM_BEATS  = 89,
  parameter logic [63:0] EXPECTED     = 64'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [IN_W-1:0]    in_data,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [WIDTH-1:0]   signature,
  output logic [COUNT_W-1:0] beat_count
`ifdef MATCH_SIGNATURE_ONES_EN
  ,
  output logic [COUNT_W-1:0] ones_count
`endif
);

  localparam logic [WIDTH-1:0]   EXP_W  = WIDTH'(EXPECTED);
  localparam logic [COUNT_W-1:0] WARM_N = COUNT_W'(WARMUP_BEATS);
  localparam logic [COUNT_W-1:0] ACC_N  = COUNT_W'(ACCUM_BEATS);

  msa_state_e         r_state;
  msa_state_e         w_state_next;
  logic [COUNT_W-1:0] r_win_cnt;     // beats accepted in the current window
  logic [COUNT_W-1:0] w_win_next;
  logic [COUNT_W-1:0] r_beat_count;
  logic               r_pass;
  logic               w_pass_load;
  logic               w_pass_val;
  logic               w_sig_clear;
  logic               w_sig_step;
  logic               w_run_clear;   // start honoured: clear all run counters
  logic               w_accept;
  logic [WIDTH-1:0]   w_sig;
  logic [WIDTH-1:0]   w_sig_next;

  assign w_accept = in_valid && (r_state == WARM || r_state == ACCUM);

  misr_reg #(
    .WIDTH (WIDTH),
    .IN_W  (IN_W)
  ) u_misr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_sig_clear),
    .i_step     (w_sig_step),
    .i_din      (in_data),
    .o_sig      (w_sig),
    .o_sig_next (w_sig_next)
  );

  always_comb begin
    w_state_next = r_state;
    w_win_next   = r_win_cnt;
    w_sig_clear  = 1'b0;
    w_sig_step   = 1'b0;
    w_run_clear  = 1'b0;
    w_pass_load  = 1'b0;
    w_pass_val   = (w_sig_next == EXP_W);
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_sig_clear = 1'b1;
          w_run_clear = 1'b1;
          w_win_next  = '0;
          // Empty windows are skipped; with both empty the zero signature
          // is compared straight away.
          if (WARM_N != '0) begin
            w_state_next = WARM;
          end else if (ACC_N != '0) begin
            w_state_next = ACCUM;
          end else begin
            w_state_next = DONE;
            w_pass_load  = 1'b1;
            w_pass_val   = (EXP_W == '0);
          end
        end
      end
      WARM: begin
        if (in_valid) begin
          w_sig_clear = 1'b1;
          if (r_win_cnt + COUNT_W'(1) == WARM_N) begin
            w_win_next = '0;
            if (ACC_N != '0) begin
              w_state_next = ACCUM;
            end else begin
              w_state_next = DONE;
              w_pass_load  = 1'b1;
              w_pass_val   = (EXP_W == '0);
            end
          end else begin
            w_win_next = r_win_cnt + COUNT_W'(1);
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          w_sig_step = 1'b1;
          if (r_win_cnt + COUNT_W'(1) == ACC_N) begin
            w_win_next   = '0;
            w_state_next = DONE;
            // Compare the value being written, so pass rises with done.
            w_pass_load  = 1'b1;
          end else begin
            w_win_next = r_win_cnt + COUNT_W'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_win_cnt    <= '0;
      r_beat_count <= '0;
      r_pass       <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_win_cnt <= w_win_next;
      if (w_run_clear) begin
        r_beat_count <= '0;
        r_pass       <= 1'b0;
      end else if (w_accept && r_beat_count != '1) begin
        r_beat_count <= r_beat_count + COUNT_W'(1);
      end
      if (w_pass_load) begin
        r_pass <= w_pass_val;
      end
    end
  end

`ifdef MATCH_SIGNATURE_ONES_EN
  logic [COUNT_W-1:0] r_ones_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones_count <= '0;
    end else if (w_run_clear) begin
      r_ones_count <= '0;
    end else if (w_accept && r_state == ACCUM && in_data[0] && r_ones_count != '1) begin
      r_ones_count <= r_ones_count + COUNT_W'(1);
    end
  end

  assign ones_count = r_ones_count;
`else
  // No ones counter in this build.
`endif

  assign busy       = (r_state == WARM) || (r_state == ACCUM);
  assign done       = (r_state == DONE);
  assign pass       = done && r_pass;
  assign signature  = w_sig;
  assign beat_count = r_beat_count;

endmodule

// File: tb/tb_match_signature_accum.sv
// tb/tb_match_signature_accum.sv - self-checking bench for match_signature_accum
module tb_match_signature_accum;

  localparam int W  = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          busy, done, pass;
  logic [W-1:0]  signature;
  logic [31:0]   beat_count;
`ifdef MATCH_SIGNATURE_ONES_EN
  logic [31:0]   ones_count;
`endif

  logic          d_start, d_in_valid;
  logic [0:0]    d_in_data;
  logic          d_busy, d_done, d_pass;
  logic [63:0]   d_signature;
  logic [31:0]   d_beat_count;
`ifdef MATCH_SIGNATURE_ONES_EN
  logic [31:0]   d_ones_count;
`endif

  always #5 clk = ~clk;

  match_signature_accum #(
    .WIDTH(W), .IN_W(IW), .WARMUP_BEATS(2), .ACCUM_BEATS(3), .EXPECTED(64'h05)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .done(done), .pass(pass), .signature(signature), .beat_count(beat_count)
`ifdef MATCH_SIGNATURE_ONES_EN
    , .ones_count(ones_count)
`endif
  );

  match_signature_accum dut_def (
    .clk(clk), .rst_n(rst_n), .start(d_start), .in_valid(d_in_valid), .in_data(d_in_data),
    .busy(d_busy), .done(d_done), .pass(d_pass), .signature(d_signature),
    .beat_count(d_beat_count)
`ifdef MATCH_SIGNATURE_ONES_EN
    , .ones_count(d_ones_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model (0 IDLE, 1 WARM, 2 ACCUM, 3 DONE)
  int           m_state;
  logic [W-1:0] m_sig;
  logic [31:0]  m_bc, m_win, m_ones;
  logic         m_pass;

  typedef struct {
    logic [W-1:0] sig;
    logic [31:0]  bc;
    logic         busy;
    logic         done;
    logic         pass;
  } exp_t;
  exp_t sb[$];

  function automatic logic [W-1:0] ref_step(input logic [W-1:0] s, input logic [IW-1:0] d);
    logic fb;
    fb = s[W-1] ^ s[2] ^ s[0];
    return {s[W-2:0], fb} ^ {{(W-IW){1'b0}}, d};
  endfunction

  task automatic model_reset();
    m_state = 0; m_sig = '0; m_bc = 0; m_win = 0; m_ones = 0; m_pass = 1'b0;
    sb.delete();
  endtask

  task automatic model_edge();
    exp_t e;
    case (m_state)
      0, 3: if (start) begin
        m_state = 1; m_sig = '0; m_bc = 0; m_win = 0; m_ones = 0; m_pass = 1'b0;
      end
      1: if (in_valid) begin
        m_bc++; m_sig = '0; m_win++;
        if (m_win == 2) begin m_state = 2; m_win = 0; end
      end
      2: if (in_valid) begin
        m_bc++; m_sig = ref_step(m_sig, in_data); m_win++;
        if (in_data[0]) m_ones++;
        if (m_win == 3) begin m_state = 3; m_win = 0; m_pass = (m_sig == 8'h05); end
      end
      default: ;
    endcase
    e.sig = m_sig; e.bc = m_bc; e.busy = (m_state == 1 || m_state == 2);
    e.done = (m_state == 3); e.pass = m_pass;
    sb.push_back(e);
  endtask

  // One clock: predict, clock, then compare the DUT against the oldest prediction.
  task automatic tick();
    exp_t e;
    model_edge();
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("sig", 64'(signature), 64'(e.sig));
      chk("beat_count", 64'(beat_count), 64'(e.bc));
      chk("busy", 64'(busy), 64'(e.busy));
      chk("done", 64'(done), 64'(e.done));
      if (e.done) chk("pass", 64'(pass), 64'(e.pass));
    end
  endtask

  typedef struct {
    logic          toggle;
    logic [IW-1:0] data;
    logic [W-1:0]  exp_sig;
    logic          exp_pass;
    int            exp_cycles;
    int            exp_ones;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int cyc;
    vecs[0] = '{toggle: 1'b0, data: 2'd1, exp_sig: 8'h05, exp_pass: 1'b1, exp_cycles: 5, exp_ones: 3};
    vecs[1] = '{toggle: 1'b1, data: 2'd1, exp_sig: 8'h05, exp_pass: 1'b1, exp_cycles: 9, exp_ones: 3};
    vecs[2] = '{toggle: 1'b0, data: 2'd0, exp_sig: 8'h00, exp_pass: 1'b0, exp_cycles: 5, exp_ones: 0};
    vecs[3] = '{toggle: 1'b0, data: 2'd3, exp_sig: 8'h0A, exp_pass: 1'b0, exp_cycles: 5, exp_ones: 3};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    d_start = 1'b0; d_in_valid = 1'b0; d_in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("def_rst_sig", d_signature, 64'h0);
    chk("def_rst_bc", 64'(d_beat_count), 64'h0);
    chk("def_rst_busy", 64'(d_busy), 64'h0);
    chk("def_rst_done", 64'(d_done), 64'h0);
    chk("def_rst_pass", 64'(d_pass), 64'h0);
    chk("rst_sig", 64'(signature), 64'h0);
    rst_n = 1'b1;
    model_reset();

    // Beats in IDLE are dropped.
    in_valid = 1'b1; in_data = 2'd1;
    tick(); tick();
    in_valid = 1'b0;

    // Table-driven runs; each start also carries a beat that must be dropped.
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; in_valid = 1'b1; in_data = vecs[i].data;
      tick();
      start = 1'b0;
`ifdef MATCH_SIGNATURE_ONES_EN
      chk("ones_clear", 64'(ones_count), 64'h0);
`endif
      cyc = 0;
      while (!done && cyc < 40) begin
        in_valid = vecs[i].toggle ? (cyc % 2 == 0) : 1'b1;
        tick();
        cyc++;
      end
      chk("done_reached", 64'(done), 64'h1);
      chk("done_cycles", 64'(cyc), 64'(vecs[i].exp_cycles));
      chk("final_sig", 64'(signature), 64'(vecs[i].exp_sig));
      chk("final_pass", 64'(pass), 64'(vecs[i].exp_pass));
      chk("final_bc", 64'(beat_count), 64'd5);
`ifdef MATCH_SIGNATURE_ONES_EN
      chk("final_ones", 64'(ones_count), 64'(vecs[i].exp_ones));
`endif
      // DONE holds while beats keep arriving.
      in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
    end

    // Restart attempt during ACCUM is ignored.
    start = 1'b1; in_valid = 1'b1; in_data = 2'd1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin tick(); cyc++; end
    chk("restart_sig", 64'(signature), 64'h05);
    chk("restart_bc", 64'(beat_count), 64'd5);
    chk("restart_pass", 64'(pass), 64'h1);

    // Asynchronous reset mid-run.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_done", 64'(done), 64'h0);
    chk("arst_pass", 64'(pass), 64'h0);
    chk("arst_sig", 64'(signature), 64'h0);
    chk("arst_bc", 64'(beat_count), 64'h0);
`ifdef MATCH_SIGNATURE_ONES_EN
    chk("arst_ones", 64'(ones_count), 64'h0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
